exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage_pkg.sv | 38 +++
 rtl/exe_stage_if.sv | 37 +++
 rtl/mul_div_unit.sv | 122 ++++++++++++
 rtl/exe_stage.sv | 132 +++++++++++++
 tb/tb_exe_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALUOp codes, funct codes,
// the mul/div sequencer state type and its iteration count.
package exe_stage_pkg;

  // ALUOp field of the EXE control bundle
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  // R-type funct codes understood by the ALU decoder
  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULTU = 6'h18;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1A;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;

  // One radix-2 step per cycle over a 32-bit operand
  localparam int unsigned MD_ITERATIONS = 32;
  localparam int unsigned MD_CNT_W      = 6;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // True for the two instructions that go through the iterative unit
  function automatic logic is_mul_div(input logic [1:0] alu_op, input logic [5:0] funct);
    return (alu_op == ALUOP_FUNCT) && ((funct == FUNCT_MULTU) || (funct == FUNCT_DIVU));
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Bundle between the ID/EX side and the execute stage, plus the EX/MEM
// register outputs. The upstream side uses the master modport.
interface exe_stage_if;
  logic [31:0] pcIn;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] sign_extended;
  logic [4:0]  instruction1;
  logic [4:0]  instruction2;
  logic [1:0]  WB;
  logic [2:0]  MEM;
  logic [3:0]  EXE;
  logic        valid;
  logic        stall;
  logic [31:0] aluResultOut;
  logic [31:0] writeDataOut;
  logic [31:0] branchTargetOut;
  logic [4:0]  writeRegOut;
  logic        zeroOut;
  logic [1:0]  WBOut;
  logic [2:0]  MEMOut;
  logic        validOut;

  modport master (
    output pcIn, readData1, readData2, sign_extended, instruction1, instruction2,
           WB, MEM, EXE, valid,
    input  stall, aluResultOut, writeDataOut, branchTargetOut, writeRegOut,
           zeroOut, WBOut, MEMOut, validOut
  );

  modport slave (
    input  pcIn, readData1, readData2, sign_extended, instruction1, instruction2,
           WB, MEM, EXE, valid,
    output stall, aluResultOut, writeDataOut, branchTargetOut, writeRegOut,
           zeroOut, WBOut, MEMOut, validOut
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiplier/divider with HI/LO result registers.
// Multiply is shift-add, divide is restoring; both take 32 BUSY cycles.
module mul_div_unit import exe_stage_pkg::*; (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        is_div_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        idle_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   count_q;
  logic                  is_div_q;
  logic [31:0]           opnd_q;     // multiplicand for multu, divisor for divu
  logic [31:0]           work_hi_q;  // product high half / partial remainder
  logic [31:0]           work_lo_q;  // multiplier bits / dividend-quotient bits
  logic [31:0]           work_hi_d, work_lo_d;
  logic [31:0]           hi_q, lo_q;
  logic [32:0]           mul_sum_s;
  logic [32:0]           div_shift_s;
  logic [31:0]           div_diff_s;
  logic                  div_ge_s;
  logic                  last_step_s;

  assign last_step_s = (count_q == MD_CNT_W'(MD_ITERATIONS - 1));

  // State register of the sequencer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= MD_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: IDLE -> BUSY on start, BUSY -> DONE after the last step, DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) state_d = MD_BUSY;
        else         state_d = MD_IDLE;
      end
      MD_BUSY: begin
        if (last_step_s) state_d = MD_DONE;
        else             state_d = MD_BUSY;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // State decode for the handshake outputs
  always_comb begin
    idle_o = 1'b0;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      MD_IDLE: idle_o = 1'b1;
      MD_BUSY: busy_o = 1'b1;
      MD_DONE: done_o = 1'b1;
      default: idle_o = 1'b0;
    endcase
  end

  // One radix-2 step of either operation, selected by the captured opcode
  always_comb begin
    mul_sum_s   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift_s = {work_hi_q, work_lo_q[31]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    div_diff_s  = div_shift_s[31:0] - opnd_q;
    if (is_div_q) begin
      work_hi_d = div_ge_s ? div_diff_s : div_shift_s[31:0];
      work_lo_d = {work_lo_q[30:0], div_ge_s};
    end else begin
      work_hi_d = mul_sum_s[32:1];
      work_lo_d = {mul_sum_s[0], work_lo_q[31:1]};
    end
  end

  // Operand capture, iteration and HI/LO commit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      is_div_q  <= 1'b0;
      opnd_q    <= 32'd0;
      work_hi_q <= 32'd0;
      work_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            count_q   <= '0;
            is_div_q  <= is_div_i;
            opnd_q    <= is_div_i ? b_i : a_i;
            work_hi_q <= 32'd0;
            work_lo_q <= is_div_i ? a_i : b_i;
          end
        end
        MD_BUSY: begin
          count_q   <= count_q + MD_CNT_W'(1);
          work_hi_q <= work_hi_d;
          work_lo_q <= work_lo_d;
        end
        MD_DONE: begin
          hi_q <= work_hi_q;
          lo_q <= work_lo_q;
        end
        default: count_q <= '0;
      endcase
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand muxes, ALU, branch target adder and the EX/MEM
// register. multu/divu are handed to mul_div_unit and stall the pipe.
module exe_stage import exe_stage_pkg::*; (
  input  logic   clock,
  input  logic   reset_n,
  exe_stage_if.slave ex
);

  logic [31:0] op_a_s, op_b_s, alu_res_s, branch_s;
  logic [4:0]  write_reg_s, shamt_s;
  logic [5:0]  funct_s;
  logic [1:0]  alu_op_s;
  logic        mul_div_s, md_start_s, md_idle_s, md_busy_s, md_done_s, load_s;
  logic [31:0] md_hi_s, md_lo_s;

  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] branch_q, branch_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        zero_q, zero_d;
  logic [1:0]  wb_q, wb_d;
  logic [2:0]  mem_q, mem_d;
  logic        valid_q, valid_d;

  assign op_a_s      = ex.readData1;
  assign op_b_s      = ex.EXE[0] ? ex.sign_extended : ex.readData2;
  assign write_reg_s = ex.EXE[3] ? ex.instruction2 : ex.instruction1;
  assign alu_op_s    = ex.EXE[2:1];
  assign funct_s     = ex.sign_extended[5:0];
  assign shamt_s     = ex.sign_extended[10:6];
  assign branch_s    = ex.pcIn + {ex.sign_extended[29:0], 2'b00};
  assign mul_div_s   = ex.valid && is_mul_div(alu_op_s, funct_s);
  assign md_start_s  = mul_div_s && md_idle_s;
  // A real instruction leaves EX unless it is a mul/div still waiting for DONE
  assign load_s      = ex.valid && (!mul_div_s || md_done_s);
  assign ex.stall    = reset_n && (md_start_s || md_busy_s);

  mul_div_unit u_mul_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .start_i  (md_start_s),
    .is_div_i (funct_s == FUNCT_DIVU),
    .a_i      (op_a_s),
    .b_i      (op_b_s),
    .idle_o   (md_idle_s),
    .busy_o   (md_busy_s),
    .done_o   (md_done_s),
    .hi_o     (md_hi_s),
    .lo_o     (md_lo_s)
  );

  // ALU: ALUOp selects add/sub/ori directly, or defers to the funct decoder
  always_comb begin
    alu_res_s = 32'd0;
    case (alu_op_s)
      ALUOP_ADD: alu_res_s = op_a_s + op_b_s;
      ALUOP_SUB: alu_res_s = op_a_s - op_b_s;
      ALUOP_ORI: alu_res_s = op_a_s | {16'h0000, ex.sign_extended[15:0]};
      ALUOP_FUNCT: begin
        case (funct_s)
          FUNCT_ADD:  alu_res_s = op_a_s + op_b_s;
          FUNCT_SUB:  alu_res_s = op_a_s - op_b_s;
          FUNCT_AND:  alu_res_s = op_a_s & op_b_s;
          FUNCT_OR:   alu_res_s = op_a_s | op_b_s;
          FUNCT_SLT:  alu_res_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
          FUNCT_SLL:  alu_res_s = op_b_s << shamt_s;
          FUNCT_MFHI: alu_res_s = md_hi_s;
          FUNCT_MFLO: alu_res_s = md_lo_s;
          default:    alu_res_s = 32'd0;
        endcase
      end
      default: alu_res_s = 32'd0;
    endcase
  end

  // EX/MEM next values: real instruction or an all-zero bubble
  always_comb begin
    alu_result_d = 32'd0;
    write_data_d = 32'd0;
    branch_d     = 32'd0;
    write_reg_d  = 5'd0;
    zero_d       = 1'b0;
    wb_d         = 2'b00;
    mem_d        = 3'b000;
    valid_d      = 1'b0;
    if (load_s) begin
      alu_result_d = alu_res_s;
      write_data_d = ex.readData2;
      branch_d     = branch_s;
      write_reg_d  = write_reg_s;
      zero_d       = (alu_res_s == 32'd0);
      wb_d         = mul_div_s ? 2'b00 : ex.WB;
      mem_d        = ex.MEM;
      valid_d      = 1'b1;
    end else begin
      valid_d      = 1'b0;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_result_q <= 32'd0;
      write_data_q <= 32'd0;
      branch_q     <= 32'd0;
      write_reg_q  <= 5'd0;
      zero_q       <= 1'b0;
      wb_q         <= 2'b00;
      mem_q        <= 3'b000;
      valid_q      <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      branch_q     <= branch_d;
      write_reg_q  <= write_reg_d;
      zero_q       <= zero_d;
      wb_q         <= wb_d;
      mem_q        <= mem_d;
      valid_q      <= valid_d;
    end
  end

  assign ex.aluResultOut    = alu_result_q;
  assign ex.writeDataOut    = write_data_q;
  assign ex.branchTargetOut = branch_q;
  assign ex.writeRegOut     = write_reg_q;
  assign ex.zeroOut         = zero_q;
  assign ex.WBOut           = wb_q;
  assign ex.MEMOut          = mem_q;
  assign ex.validOut        = valid_q;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed and random instructions checked against a
// behavioural model using plain arithmetic and 64-bit multiply/divide.
module tb_exe_stage;

  logic clock;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  exe_stage_if ex_if ();

  exe_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ex      (ex_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " alu"},    ex_if.aluResultOut, 32'd0);
    chk({tag, " wdata"},  ex_if.writeDataOut, 32'd0);
    chk({tag, " btgt"},   ex_if.branchTargetOut, 32'd0);
    chk({tag, " wreg"},   32'(ex_if.writeRegOut), 32'd0);
    chk({tag, " zero"},   32'(ex_if.zeroOut), 32'd0);
    chk({tag, " wb"},     32'(ex_if.WBOut), 32'd0);
    chk({tag, " mem"},    32'(ex_if.MEMOut), 32'd0);
    chk({tag, " valid"},  32'(ex_if.validOut), 32'd0);
    chk({tag, " stall"},  32'(ex_if.stall), 32'd0);
  endtask

  task automatic drive(input logic [31:0] pc, a, b, imm, input logic [4:0] rt, rd,
                       input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] exe,
                       input logic v);
    ex_if.pcIn          = pc;
    ex_if.readData1     = a;
    ex_if.readData2     = b;
    ex_if.sign_extended = imm;
    ex_if.instruction1  = rt;
    ex_if.instruction2  = rd;
    ex_if.WB            = wb;
    ex_if.MEM           = mem;
    ex_if.EXE           = exe;
    ex_if.valid         = v;
  endtask

  // Instruction semantics written directly from the ISA description
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a, b, imm,
                                          input logic [31:0] hi, lo);
    logic [5:0] f;
    f = imm[5:0];
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    if (op == 2'b11) return a | (imm & 32'h0000FFFF);
    if (f == 6'h20) return a + b;
    if (f == 6'h22) return a - b;
    if (f == 6'h24) return a & b;
    if (f == 6'h25) return a | b;
    if (f == 6'h2A) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (f == 6'h00) return b << imm[10:6];
    if (f == 6'h10) return hi;
    if (f == 6'h12) return lo;
    return 32'd0;
  endfunction

  // Apply one instruction, wait out any mul/div, check the EX/MEM register
  task automatic issue(input string tag, input logic [31:0] pc, a, b, imm,
                       input logic [4:0] rt, rd, input logic [1:0] wb, input logic [2:0] mem,
                       input logic [3:0] exe, input logic v);
    logic [31:0] opb, exp_res;
    logic [63:0] prod;
    logic        md;
    int          n;
    drive(pc, a, b, imm, rt, rd, wb, mem, exe, v);
    opb = exe[0] ? imm : b;
    md  = v && (exe[2:1] == 2'b10) && ((imm[5:0] == 6'h18) || (imm[5:0] == 6'h1A));
    exp_res = ref_alu(exe[2:1], a, opb, imm, hi_m, lo_m);
    #1;
    if (md) begin
      n = 0;
      while ((ex_if.stall === 1'b1) && (n < 100)) begin
        n++;
        tick();
      end
      chk({tag, " stall cycles"}, 32'(n), 32'd33);
      tick();
      if (imm[5:0] == 6'h18) begin
        prod = 64'(a) * 64'(opb);
        hi_m = prod[63:32];
        lo_m = prod[31:0];
      end else if (opb == 32'd0) begin
        hi_m = a;
        lo_m = 32'hFFFF_FFFF;
      end else begin
        hi_m = a % opb;
        lo_m = a / opb;
      end
    end else begin
      chk({tag, " stall"}, 32'(ex_if.stall), 32'd0);
      tick();
    end
    if (v) begin
      if (!md) begin
        chk({tag, " alu"},  ex_if.aluResultOut, exp_res);
        chk({tag, " zero"}, 32'(ex_if.zeroOut), (exp_res == 32'd0) ? 32'd1 : 32'd0);
      end
      chk({tag, " wdata"}, ex_if.writeDataOut, b);
      chk({tag, " btgt"},  ex_if.branchTargetOut, pc + imm * 32'd4);
      chk({tag, " wreg"},  32'(ex_if.writeRegOut), exe[3] ? 32'(rd) : 32'(rt));
      chk({tag, " wb"},    32'(ex_if.WBOut), md ? 32'd0 : 32'(wb));
      chk({tag, " mem"},   32'(ex_if.MEMOut), 32'(mem));
      chk({tag, " valid"}, 32'(ex_if.validOut), 32'd1);
    end else begin
      chk_all_zero({tag, " bubble"});
    end
  endtask

  initial begin
    logic [5:0]  tbl [12];
    logic [31:0] ra, rb, rimm;
    logic [1:0]  rop;
    logic [3:0]  rexe;
    tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h10, 6'h12, 6'h18, 6'h1A, 6'h3F, 6'h07};

    // Reset state
    reset_n = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00, 3'b000, 4'b0000, 1'b0);
    #12;
    chk_all_zero("reset");
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Directed cases
    issue("add",  32'h0, 32'd5, 32'd7, 32'h20, 5'd2, 5'd3, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("slt",  32'h4, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd4, 5'd5, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("beq",  32'h100, 32'd3, 32'd3, 32'd4, 5'd6, 5'd7, 2'b00, 3'b100, 4'b0010, 1'b1);
    issue("ori",  32'h8, 32'h1234_0000, 32'd9, 32'hFFFF_8001, 5'd8, 5'd9, 2'b10, 3'b000, 4'b0111, 1'b1);
    issue("nop",  32'h8, 32'd1, 32'd2, 32'h20, 5'd8, 5'd9, 2'b11, 3'b111, 4'b1100, 1'b0);
    issue("mfhi0", 32'h0, 32'd0, 32'd0, 32'h10, 5'd1, 5'd1, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("multu", 32'h20, 32'h0001_0000, 32'h0001_0000, 32'h18, 5'd1, 5'd2, 2'b10, 3'b001, 4'b1100, 1'b1);
    issue("mfhi1", 32'h24, 32'd0, 32'd0, 32'h10, 5'd1, 5'd10, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("mflo1", 32'h28, 32'd0, 32'd0, 32'h12, 5'd1, 5'd11, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("divu0", 32'h2C, 32'd7, 32'd0, 32'h1A, 5'd1, 5'd2, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("mfhi2", 32'h30, 32'd0, 32'd0, 32'h10, 5'd1, 5'd12, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("mflo2", 32'h34, 32'd0, 32'd0, 32'h12, 5'd1, 5'd13, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("divu",  32'h38, 32'd100, 32'd7, 32'h1A, 5'd1, 5'd2, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("mfhi3", 32'h3C, 32'd0, 32'd0, 32'h10, 5'd1, 5'd14, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("mflo3", 32'h40, 32'd0, 32'd0, 32'h12, 5'd1, 5'd15, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("sll",   32'h44, 32'd0, 32'h8000_0003, 32'h0000_0040, 5'd1, 5'd16, 2'b10, 3'b000, 4'b1100, 1'b1);

    // Random instructions, including the occasional mul/div
    for (int i = 0; i < 40; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rexe = {1'($urandom), rop, 1'($urandom)};
      rimm = $urandom;
      if (rop == 2'b10) rimm[5:0] = tbl[$urandom_range(0, 11)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      issue("rand", $urandom, ra, rb, rimm, 5'($urandom), 5'($urandom), 2'($urandom),
            3'($urandom), rexe, ($urandom_range(0, 7) != 0));
    end

    // Reset in the middle of a multiply
    drive(32'h50, 32'd5, 32'd6, 32'h18, 5'd1, 5'd2, 2'b10, 3'b000, 4'b1100, 1'b1);
    #1;
    chk("abort issue stall", 32'(ex_if.stall), 32'd1);
    for (int k = 0; k < 10; k++) tick();
    chk("abort busy stall", 32'(ex_if.stall), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("abort");
    hi_m = 32'd0;
    lo_m = 32'd0;
    ex_if.valid = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    issue("post mfhi", 32'h60, 32'd0, 32'd0, 32'h10, 5'd1, 5'd3, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("post mflo", 32'h64, 32'd0, 32'd0, 32'h12, 5'd1, 5'd4, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("post add",  32'h68, 32'd40, 32'd2, 32'h20, 5'd1, 5'd5, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("post mul",  32'h6C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h18, 5'd1, 5'd2, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("post mfhi2", 32'h70, 32'd0, 32'd0, 32'h10, 5'd1, 5'd6, 2'b10, 3'b000, 4'b1100, 1'b1);
    issue("post mflo2", 32'h74, 32'd0, 32'd0, 32'h12, 5'd1, 5'd7, 2'b10, 3'b000, 4'b1100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
